// File: rtl/commit_redirect_ctrl_pkg.sv
// rtl/commit_redirect_ctrl_pkg.sv - shared types and constants for the commit redirect controller
package commit_redirect_ctrl_pkg;

  localparam int          EXCCODE_W  = 5;
  localparam int          DRAIN_W    = 3;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [1:0] {IDLE, WAIT_DS, DRAIN} state_t;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic                 is_br;
    logic                 mispred;
    logic [31:0]          target;
    logic                 exc;
    logic [EXCCODE_W-1:0] exccode;
  } commit_slot_t;

  localparam int SLOT_W = $bits(commit_slot_t);

  // Outcome of one commit cycle as seen from IDLE.
  typedef struct packed {
    logic                 flush;
    logic                 exc;
    logic                 wait_ds;
    logic [31:0]          redirect;
    logic [31:0]          epc;
    logic [EXCCODE_W-1:0] code;
    logic                 bd;
    logic [31:0]          br_pc;
    logic [31:0]          br_target;
  } pick_t;

  localparam int PICK_W = $bits(pick_t);

endpackage

// File: rtl/commit_redirect_ctrl_pick.sv
// rtl/commit_redirect_ctrl_pick.sv - two-slot oldest-first event resolver for IDLE commits
module commit_redirect_ctrl_pick #(
  parameter logic [31:0] EXC_VECTOR = commit_redirect_ctrl_pkg::EXC_VECTOR
) (
  input  logic [commit_redirect_ctrl_pkg::SLOT_W-1:0] i_slot0,
  input  logic [commit_redirect_ctrl_pkg::SLOT_W-1:0] i_slot1,
  output logic [commit_redirect_ctrl_pkg::PICK_W-1:0] o_evt
);
  import commit_redirect_ctrl_pkg::*;

  commit_slot_t w_s0;
  commit_slot_t w_s1;
  pick_t        w_evt;

  assign w_s0  = i_slot0;
  assign w_s1  = i_slot1;
  assign o_evt = w_evt;

  always_comb begin
    w_evt = '0;
    if (w_s0.valid) begin
      if (w_s0.exc) begin
        w_evt.flush    = 1'b1;
        w_evt.exc      = 1'b1;
        w_evt.redirect = EXC_VECTOR;
        w_evt.epc      = w_s0.pc;
        w_evt.code     = w_s0.exccode;
      end else if (w_s0.is_br && w_s0.mispred) begin
        // Slot1 is the delay slot of this branch when present.
        if (w_s1.valid && w_s1.exc) begin
          w_evt.flush    = 1'b1;
          w_evt.exc      = 1'b1;
          w_evt.redirect = EXC_VECTOR;
          w_evt.epc      = w_s0.pc;
          w_evt.code     = w_s1.exccode;
          w_evt.bd       = 1'b1;
        end else if (w_s1.valid) begin
          w_evt.flush    = 1'b1;
          w_evt.redirect = w_s0.target;
        end else begin
          w_evt.wait_ds   = 1'b1;
          w_evt.br_pc     = w_s0.pc;
          w_evt.br_target = w_s0.target;
        end
      end else if (w_s1.valid && w_s1.exc) begin
        w_evt.flush    = 1'b1;
        w_evt.exc      = 1'b1;
        w_evt.redirect = EXC_VECTOR;
        w_evt.epc      = w_s1.pc;
        w_evt.code     = w_s1.exccode;
      end else if (w_s1.valid && w_s1.is_br && w_s1.mispred) begin
        w_evt.wait_ds   = 1'b1;
        w_evt.br_pc     = w_s1.pc;
        w_evt.br_target = w_s1.target;
      end
    end
  end

endmodule

// File: rtl/commit_redirect_ctrl.sv
// rtl/commit_redirect_ctrl.sv - commit-side flush/redirect FSM with delay-slot wait and drain blackout
module commit_redirect_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = commit_redirect_ctrl_pkg::EXC_VECTOR,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_c0_valid,
  input  logic [31:0] i_c0_pc,
  input  logic        i_c0_is_br,
  input  logic        i_c0_mispred,
  input  logic [31:0] i_c0_target,
  input  logic        i_c0_exc,
  input  logic [4:0]  i_c0_exccode,
  input  logic        i_c1_valid,
  input  logic [31:0] i_c1_pc,
  input  logic        i_c1_is_br,
  input  logic        i_c1_mispred,
  input  logic [31:0] i_c1_target,
  input  logic        i_c1_exc,
  input  logic [4:0]  i_c1_exccode,
  output logic        o_flush_req,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_exc_valid,
  output logic [4:0]  o_exc_code,
  output logic [31:0] o_exc_epc,
  output logic        o_exc_bd,
  output logic        o_commit_single,
  output logic        o_commit_block
);
  import commit_redirect_ctrl_pkg::*;

  commit_slot_t w_s0;
  commit_slot_t w_s1;
  pick_t        w_evt;
  logic [PICK_W-1:0] w_evt_bits;

  assign w_s0 = '{valid: i_c0_valid, pc: i_c0_pc, is_br: i_c0_is_br, mispred: i_c0_mispred,
                  target: i_c0_target, exc: i_c0_exc, exccode: i_c0_exccode};
  assign w_s1 = '{valid: i_c1_valid, pc: i_c1_pc, is_br: i_c1_is_br, mispred: i_c1_mispred,
                  target: i_c1_target, exc: i_c1_exc, exccode: i_c1_exccode};
  assign w_evt = w_evt_bits;

  commit_redirect_ctrl_pick #(.EXC_VECTOR(EXC_VECTOR)) u_pick (
    .i_slot0 (w_s0),
    .i_slot1 (w_s1),
    .o_evt   (w_evt_bits)
  );

  state_t               r_state;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [31:0]          r_br_pc;
  logic [31:0]          r_br_target;
  logic                 r_flush_req;
  logic                 r_redirect_valid;
  logic [31:0]          r_redirect_pc;
  logic                 r_exc_valid;
  logic [EXCCODE_W-1:0] r_exc_code;
  logic [31:0]          r_exc_epc;
  logic                 r_exc_bd;
  logic                 r_commit_single;
  logic                 r_commit_block;

  logic                 w_fire;
  logic                 w_exc;
  logic [31:0]          w_redirect;
  logic [31:0]          w_epc;
  logic [EXCCODE_W-1:0] w_code;
  logic                 w_bd;

  always_comb begin
    w_fire     = 1'b0;
    w_exc      = 1'b0;
    w_redirect = '0;
    w_epc      = '0;
    w_code     = '0;
    w_bd       = 1'b0;
    case (r_state)
      IDLE: begin
        w_fire     = w_evt.flush;
        w_exc      = w_evt.exc;
        w_redirect = w_evt.redirect;
        w_epc      = w_evt.epc;
        w_code     = w_evt.code;
        w_bd       = w_evt.bd;
      end
      WAIT_DS: begin
        // Only slot0 is presented here, and it is the delay slot.
        if (i_c0_valid) begin
          w_fire = 1'b1;
          if (i_c0_exc) begin
            w_exc      = 1'b1;
            w_redirect = EXC_VECTOR;
            w_epc      = r_br_pc;
            w_code     = i_c0_exccode;
            w_bd       = 1'b1;
          end else begin
            w_redirect = r_br_target;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_drain_cnt      <= '0;
      r_br_pc          <= '0;
      r_br_target      <= '0;
      r_flush_req      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_exc_valid      <= 1'b0;
      r_exc_code       <= '0;
      r_exc_epc        <= '0;
      r_exc_bd         <= 1'b0;
      r_commit_single  <= 1'b0;
      r_commit_block   <= 1'b0;
    end else begin
      r_flush_req      <= w_fire;
      r_redirect_valid <= w_fire;
      r_exc_valid      <= w_fire & w_exc;
      if (w_fire) begin
        r_redirect_pc   <= w_redirect;
        r_exc_epc       <= w_epc;
        r_exc_code      <= w_code;
        r_exc_bd        <= w_bd;
        r_state         <= DRAIN;
        r_drain_cnt     <= DRAIN_W'(DRAIN_CYCLES);
        r_commit_block  <= 1'b1;
        r_commit_single <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_evt.wait_ds) begin
              r_br_pc         <= w_evt.br_pc;
              r_br_target     <= w_evt.br_target;
              r_state         <= WAIT_DS;
              r_commit_single <= 1'b1;
            end
          end
          DRAIN: begin
            if (r_drain_cnt <= DRAIN_W'(1)) begin
              r_state        <= IDLE;
              r_drain_cnt    <= '0;
              r_commit_block <= 1'b0;
            end else begin
              r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_flush_req      = r_flush_req;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_exc_valid      = r_exc_valid;
  assign o_exc_code       = r_exc_code;
  assign o_exc_epc        = r_exc_epc;
  assign o_exc_bd         = r_exc_bd;
  assign o_commit_single  = r_commit_single;
  assign o_commit_block   = r_commit_block;

endmodule

// File: tb/tb_commit_redirect_ctrl.sv
// tb/tb_commit_redirect_ctrl.sv - directed bench with in-order commit-stream reference model
module tb_commit_redirect_ctrl;
  import commit_redirect_ctrl_pkg::*;

  localparam int          DRAIN = 2;
  localparam logic [31:0] VEC   = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  commit_slot_t in0, in1;

  logic        o_flush_req, o_redirect_valid, o_exc_valid, o_exc_bd;
  logic        o_commit_single, o_commit_block;
  logic [31:0] o_redirect_pc, o_exc_epc;
  logic [4:0]  o_exc_code;

  always #5 clk = ~clk;

  commit_redirect_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_c0_valid(in0.valid), .i_c0_pc(in0.pc), .i_c0_is_br(in0.is_br), .i_c0_mispred(in0.mispred),
    .i_c0_target(in0.target), .i_c0_exc(in0.exc), .i_c0_exccode(in0.exccode),
    .i_c1_valid(in1.valid), .i_c1_pc(in1.pc), .i_c1_is_br(in1.is_br), .i_c1_mispred(in1.mispred),
    .i_c1_target(in1.target), .i_c1_exc(in1.exc), .i_c1_exccode(in1.exccode),
    .o_flush_req(o_flush_req), .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_exc_valid(o_exc_valid), .o_exc_code(o_exc_code), .o_exc_epc(o_exc_epc), .o_exc_bd(o_exc_bd),
    .o_commit_single(o_commit_single), .o_commit_block(o_commit_block)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic commit_slot_t mk(input bit v, input logic [31:0] pc, input bit br, input bit mp,
                                      input logic [31:0] tg, input bit ex, input logic [4:0] code);
    commit_slot_t s;
    s.valid = v; s.pc = pc; s.is_br = br; s.mispred = mp;
    s.target = tg; s.exc = ex; s.exccode = code;
    return s;
  endfunction

  function automatic commit_slot_t norm(input logic [31:0] pc);
    return mk(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
  endfunction
  function automatic commit_slot_t misp(input logic [31:0] pc, input logic [31:0] tg);
    return mk(1'b1, pc, 1'b1, 1'b1, tg, 1'b0, 5'h0);
  endfunction
  function automatic commit_slot_t excs(input logic [31:0] pc, input logic [4:0] code);
    return mk(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b1, code);
  endfunction

  // Reference model: walks the committed instructions in program order.
  bit          e_flush, e_rv, e_exc, e_bd, e_single, e_block;
  logic [31:0] e_pc, e_epc, m_br_pc, m_br_tgt;
  logic [4:0]  e_code;
  int          blackout;
  bit          pending;

  initial begin
    e_flush = 0; e_rv = 0; e_exc = 0; e_bd = 0; e_single = 0; e_block = 0;
    e_pc = 0; e_epc = 0; e_code = 0; blackout = 0; pending = 0;
    m_br_pc = 0; m_br_tgt = 0;
  end

  task automatic take_br(input logic [31:0] tgt);
    e_flush = 1; e_rv = 1; e_pc = tgt; blackout = DRAIN;
  endtask

  task automatic take_exc(input logic [4:0] code, input logic [31:0] epc, input bit bd);
    e_flush = 1; e_rv = 1; e_exc = 1; e_pc = VEC;
    e_code = code; e_epc = epc; e_bd = bd; blackout = DRAIN;
  endtask

  task automatic scan();
    commit_slot_t q[$];
    if (in0.valid) q.push_back(in0);
    if (in1.valid) q.push_back(in1);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].exc) begin
        take_exc(q[i].exccode, q[i].pc, 1'b0);
        break;
      end
      if (q[i].is_br && q[i].mispred) begin
        if (i + 1 < q.size()) begin
          if (q[i+1].exc) take_exc(q[i+1].exccode, q[i].pc, 1'b1);
          else            take_br(q[i].target);
        end else begin
          pending  = 1;
          m_br_pc  = q[i].pc;
          m_br_tgt = q[i].target;
        end
        break;
      end
    end
  endtask

  always @(posedge clk) begin
    e_flush = 0; e_rv = 0; e_exc = 0;
    if (rst) begin
      blackout = 0; pending = 0;
    end else if (blackout > 0) begin
      blackout--;
    end else if (pending) begin
      if (in0.valid) begin
        pending = 0;
        if (in0.exc) take_exc(in0.exccode, m_br_pc, 1'b1);
        else         take_br(m_br_tgt);
      end
    end else begin
      scan();
    end
    e_block  = (blackout > 0);
    e_single = pending;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("flush_req",      32'(o_flush_req),      32'(e_flush));
      chk("redirect_valid", 32'(o_redirect_valid), 32'(e_rv));
      chk("exc_valid",      32'(o_exc_valid),      32'(e_exc));
      chk("commit_single",  32'(o_commit_single),  32'(e_single));
      chk("commit_block",   32'(o_commit_block),   32'(e_block));
      if (e_flush) chk("redirect_pc", o_redirect_pc, e_pc);
      if (e_exc) begin
        chk("exc_epc",  o_exc_epc,         e_epc);
        chk("exc_code", 32'(o_exc_code),   32'(e_code));
        chk("exc_bd",   32'(o_exc_bd),     32'(e_bd));
      end
    end
  end

  task automatic cyc(input commit_slot_t a, input commit_slot_t b);
    in0 = a;
    in1 = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc('0, '0);
  endtask

  initial begin
    rst = 1'b1;
    in0 = '0;
    in1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_flush",  32'(o_flush_req),     32'h0);
    chk("rst_block",  32'(o_commit_block),  32'h0);
    chk("rst_single", 32'(o_commit_single), 32'h0);
    chk("rst_rpc",    o_redirect_pc,        32'h0);
    chk("rst_epc",    o_exc_epc,            32'h0);
    rst = 1'b0;
    check_en = 1'b1;
    idle(1);

    cyc(excs(32'h8000_0010, 5'd4), '0);
    chk("t1_flush", 32'(o_flush_req), 32'h1);
    chk("t1_rpc",   o_redirect_pc,    32'hBFC0_0380);
    chk("t1_epc",   o_exc_epc,        32'h8000_0010);
    chk("t1_bd",    32'(o_exc_bd),    32'h0);
    chk("t1_code",  32'(o_exc_code),  32'h4);
    chk("t1_blk0",  32'(o_commit_block), 32'h1);
    idle(1);
    chk("t1_blk1",  32'(o_commit_block), 32'h1);
    idle(1);
    chk("t1_blk2",  32'(o_commit_block), 32'h0);

    cyc(misp(32'h8000_0100, 32'h8000_0200), norm(32'h8000_0104));
    chk("t2_flush", 32'(o_flush_req), 32'h1);
    chk("t2_rpc",   o_redirect_pc,    32'h8000_0200);
    chk("t2_exc",   32'(o_exc_valid), 32'h0);
    idle(2);

    cyc(misp(32'h8000_0100, 32'h8000_0200), '0);
    chk("t3_single0", 32'(o_commit_single), 32'h1);
    idle(3);
    chk("t3_single3", 32'(o_commit_single), 32'h1);
    cyc(norm(32'h8000_0104), '0);
    chk("t3_flush",  32'(o_flush_req),     32'h1);
    chk("t3_rpc",    o_redirect_pc,        32'h8000_0200);
    chk("t3_single", 32'(o_commit_single), 32'h0);
    idle(2);

    cyc(misp(32'h8000_0100, 32'h8000_0200), '0);
    cyc(excs(32'h8000_0104, 5'hA), misp(32'h8000_0108, 32'h8000_0500));
    chk("t4_exc",  32'(o_exc_valid), 32'h1);
    chk("t4_epc",  o_exc_epc,        32'h8000_0100);
    chk("t4_bd",   32'(o_exc_bd),    32'h1);
    chk("t4_code", 32'(o_exc_code),  32'hA);
    chk("t4_rpc",  o_redirect_pc,    32'hBFC0_0380);
    idle(2);

    cyc(excs(32'h8000_0300, 5'd4), misp(32'h8000_0304, 32'h8000_0400));
    chk("t5_exc", 32'(o_exc_valid), 32'h1);
    chk("t5_epc", o_exc_epc,        32'h8000_0300);
    cyc(excs(32'h8000_0310, 5'd7), '0);
    chk("t5_drain_exc", 32'(o_flush_req), 32'h0);
    cyc(misp(32'h8000_0320, 32'h8000_0400), norm(32'h8000_0324));
    chk("t5_drain_br", 32'(o_flush_req), 32'h0);
    idle(1);
    chk("t5_after", 32'(o_flush_req), 32'h0);

    cyc(norm(32'h8000_0600), excs(32'h8000_0604, 5'h8));
    chk("t6a_epc", o_exc_epc,     32'h8000_0604);
    chk("t6a_bd",  32'(o_exc_bd), 32'h0);
    idle(2);
    cyc(misp(32'h8000_0700, 32'h8000_0800), excs(32'h8000_0704, 5'hC));
    chk("t6b_epc",  o_exc_epc,        32'h8000_0700);
    chk("t6b_code", 32'(o_exc_code),  32'hC);
    idle(2);
    cyc(norm(32'h8000_0900), misp(32'h8000_0904, 32'h8000_0A00));
    chk("t6c_single", 32'(o_commit_single), 32'h1);
    cyc(norm(32'h8000_0908), '0);
    chk("t6c_rpc", o_redirect_pc, 32'h8000_0A00);
    idle(2);
    cyc(mk(1'b1, 32'h8000_0B00, 1'b1, 1'b0, 32'h8000_0C00, 1'b0, 5'h0), '0);
    chk("t6d_flush",  32'(o_flush_req),     32'h0);
    chk("t6d_single", 32'(o_commit_single), 32'h0);

    cyc(misp(32'h8000_0100, 32'h8000_0200), '0);
    chk("t7_single", 32'(o_commit_single), 32'h1);
    rst = 1'b1;
    cyc('0, '0);
    chk("t7_single_rst", 32'(o_commit_single), 32'h0);
    chk("t7_rpc_rst",    o_redirect_pc,        32'h0);
    chk("t7_epc_rst",    o_exc_epc,            32'h0);
    rst = 1'b0;
    cyc(norm(32'h8000_0104), '0);
    chk("t7_flush", 32'(o_flush_req), 32'h0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
